micro_besm_cpu: RTL and testbench
=================================

Name: micro_besm_cpu

Overview:
- Microprogrammed CPU core for the micro-BESM model.
- Executes one 112-bit microinstruction per clock from an internal 4096-entry control store named `memory`. The bench preloads `memory` hierarchically.
- Drives a shared 64-bit address/data bus with 8-bit tags to a tagged word RAM. Bus transfers are an address strobe followed by batch reads or writes; the RAM auto-increments the address on each transfer.

Parameters:
- UADDR_W, 12, control-store address width (4096 words).
- UWORD_W, 112, microinstruction width.
- RSTACK_D, 4, microsubroutine return-stack depth.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_data  in  64  read data from RAM; valid the cycle after o_rd.
- i_tag  in  8  read tag from RAM; same timing as i_data.
- o_ad  out  64  address (bits 19:0 on strobe) or write data.
- o_tag  out  8  write tag.
- o_astb  out  1  address strobe.
- o_rd  out  1  read request.
- o_wr  out  1  write request.

Behaviour:
- State:
  - pc[11:0]; registers A, B, D (64 bits each); T (8 bits); zero flag Z = (A==0).
  - Return stack of RSTACK_D entries, plus stack pointer; halted flag.
  - `memory[0:4095]` is 112 bits wide with a combinational read at pc. Reset does not clear it.
- Reset (reset=0, asynchronous):
  - pc=0; A, B, D, T = 0; stack pointer 0; halted=0.
  - o_ad=0, o_tag=0, o_astb=0, o_rd=0, o_wr=0.
  - First microinstruction executed is memory[0] on the first rising edge after release.
- Microword fields:
  - [111:100] NEXT: jump target.
  - [99:96] SEQ: 0 pc+1; 1 jump NEXT; 2 jump if Z; 3 jump if !Z; 4 call (push pc+1, jump NEXT); 5 return (pop); 6 halt; 7-15 treated as 0.
  - [95:92] BUS: 0 idle; 1 strobe; 2 read; 3 write; others idle.
  - [91:88] ALU: 0 nop; 1 A=LIT; 2 A=A+B; 3 A=A-B; 4 A=A&B; 5 A=A|B; 6 A=A^B; 7 A=i_data and T=i_tag; 8 B=A; 9 D=A; 10 A=A+1; 11 A=A<<1; 12 A=A>>1 (logical); 13 T=LIT[7:0]; 14-15 nop.
  - [87:64] reserved, ignored.
  - [63:0] LIT.
  - Arithmetic is modulo 2^64; carries are discarded.
- Bus outputs are registered and appear the cycle after the microinstruction that requests them. Each is held for exactly one cycle.
  - Strobe: o_astb=1, o_ad={44'b0, A[19:0]}.
  - Write: o_wr=1, o_ad=D, o_tag=T.
  - Read: o_rd=1, o_ad=0.
  - At most one of o_astb, o_rd, o_wr is high in any cycle.
- Read latency: the RAM samples o_rd on an edge and presents i_data/i_tag after that same edge. Code must place ALU=7 in the microinstruction two after the read request. Consecutive reads/writes form a batch at incrementing addresses.
- ALU and BUS in the same microword: the bus uses register values from before the ALU update.
- Sequencing corner cases:
  - pc wraps 4095 -> 0.
  - Call on a full stack overwrites the top entry.
  - Return on an empty stack jumps to 0.
  - Halt holds pc, suppresses all register and bus updates, and sets halted. Only reset clears halted.
- Reset asserted mid-transfer aborts it: outputs go low immediately.

Optional Feature:
- MICRO_BESM_TRACE_EN: when defined, the core includes a simulation-only tracer.
  - At each executed microinstruction it prints pc, the 112-bit word in hex, and any changed A/B/D/T values.
  - It also prints each bus cycle as "ASTB addr", "RD data tag" or "WR data tag".
- When the macro is undefined, no trace logic or system tasks exist and cycle behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> all outputs 0, pc=0; memory[0] executes on the first edge.
- Store: A=LIT 0x100; strobe; A=LIT 0xDEAD; D=A; T=LIT 0x05; write -> o_astb with o_ad=0x100, then o_wr with o_ad=0xDEAD, o_tag=0x05; RAM[0x100]=0xDEAD, tag 5.
- Batch load: RAM[0x200..0x201]=7,9; strobe 0x200; read; read; A=IN; B=A; A=IN; A=A+B -> A=16, T=tag of word 0x201.
- Loop: A=LIT 3; then A=A-B with B=1, jump-if-!Z back -> exactly 3 iterations; exits when A=0.
- Call/return: call to 0x40, which executes return -> pc resumes at caller+1. Return on an empty stack -> pc=0.
- Halt: SEQ=6 at pc 5 -> pc stays 5 and no bus activity for 100 cycles. Asserting reset restarts at 0.

Source files
------------

// File: rtl/micro_besm_cpu.sv
// micro_besm_cpu: microprogrammed micro-BESM core executing one 112-bit microword per clock from `memory`.
// Define MICRO_BESM_TRACE_EN to build in a simulation-only execution and bus tracer.
module micro_besm_cpu #(
    parameter int UADDR_W  = 12,
    parameter int UWORD_W  = 112,
    parameter int RSTACK_D = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] i_data,
    input  logic [7:0]  i_tag,
    output logic [63:0] o_ad,
    output logic [7:0]  o_tag,
    output logic        o_astb,
    output logic        o_rd,
    output logic        o_wr
);
    localparam int SP_W  = $clog2(RSTACK_D + 1);
    localparam int IDX_W = (RSTACK_D > 1) ? $clog2(RSTACK_D) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(RSTACK_D);

    localparam logic [3:0] SEQ_JMP  = 4'd1;
    localparam logic [3:0] SEQ_JZ   = 4'd2;
    localparam logic [3:0] SEQ_JNZ  = 4'd3;
    localparam logic [3:0] SEQ_CALL = 4'd4;
    localparam logic [3:0] SEQ_RET  = 4'd5;
    localparam logic [3:0] SEQ_HALT = 4'd6;

    localparam logic [3:0] BUS_STB = 4'd1;
    localparam logic [3:0] BUS_RD  = 4'd2;
    localparam logic [3:0] BUS_WR  = 4'd3;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    logic [UWORD_W-1:0] memory [0:(2**UADDR_W)-1];

    logic [UWORD_W-1:0] uword;
    logic [UADDR_W-1:0] nxt;
    logic [3:0]         seq;
    logic [3:0]         bus;
    logic [3:0]         alu;
    logic [63:0]        lit;
    logic               reserved_unused;

    state_t             state_q, state_d;
    logic [UADDR_W-1:0] pc_q, pc_d;
    logic [UADDR_W-1:0] pc_inc;
    logic [63:0]        a_q, a_d;
    logic [63:0]        b_q, b_d;
    logic [63:0]        dr_q, dr_d;
    logic [7:0]         t_q, t_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic               z;

    logic [UADDR_W-1:0] rstack_q [RSTACK_D];
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   push_idx;
    logic               push_en;

    logic               astb_q, astb_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [63:0]        ad_q, ad_d;
    logic [7:0]         tag_q, tag_d;

    assign uword           = memory[pc_q];
    assign nxt             = uword[100 +: UADDR_W];
    assign seq             = uword[99:96];
    assign bus             = uword[95:92];
    assign alu             = uword[91:88];
    assign lit             = uword[63:0];
    assign reserved_unused = ^uword[87:64];

    assign pc_inc  = pc_q + 1'b1;
    assign z       = (a_q == '0);
    assign top_idx = IDX_W'(sp_q - 1'b1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        dr_d     = dr_q;
        t_d      = t_q;
        sp_d     = sp_q;
        astb_d   = 1'b0;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        ad_d     = '0;
        tag_d    = '0;
        push_en  = 1'b0;
        // A call on a full stack reuses the top slot instead of growing.
        push_idx = (sp_q == SP_FULL) ? top_idx : IDX_W'(sp_q);

        if (state_q == ST_RUN) begin
            if (seq == SEQ_HALT) begin
                state_d = ST_HALT;
            end else begin
                // Bus fields read the registers as they stood before this word's ALU update.
                case (bus)
                    BUS_STB: begin
                        astb_d = 1'b1;
                        ad_d   = {44'b0, a_q[19:0]};
                    end
                    BUS_RD: rd_d = 1'b1;
                    BUS_WR: begin
                        wr_d  = 1'b1;
                        ad_d  = dr_q;
                        tag_d = t_q;
                    end
                    default: ;
                endcase

                case (alu)
                    4'd1:  a_d = lit;
                    4'd2:  a_d = a_q + b_q;
                    4'd3:  a_d = a_q - b_q;
                    4'd4:  a_d = a_q & b_q;
                    4'd5:  a_d = a_q | b_q;
                    4'd6:  a_d = a_q ^ b_q;
                    4'd7: begin
                        a_d = i_data;
                        t_d = i_tag;
                    end
                    4'd8:  b_d = a_q;
                    4'd9:  dr_d = a_q;
                    4'd10: a_d = a_q + 64'd1;
                    4'd11: a_d = {a_q[62:0], 1'b0};
                    4'd12: a_d = {1'b0, a_q[63:1]};
                    4'd13: t_d = lit[7:0];
                    default: ;
                endcase

                case (seq)
                    SEQ_JMP: pc_d = nxt;
                    SEQ_JZ:  pc_d = z ? nxt : pc_inc;
                    SEQ_JNZ: pc_d = z ? pc_inc : nxt;
                    SEQ_CALL: begin
                        push_en = 1'b1;
                        pc_d    = nxt;
                        if (sp_q != SP_FULL) begin
                            sp_d = sp_q + 1'b1;
                        end
                    end
                    SEQ_RET: begin
                        if (sp_q == '0) begin
                            pc_d = '0;
                        end else begin
                            pc_d = rstack_q[top_idx];
                            sp_d = sp_q - 1'b1;
                        end
                    end
                    default: pc_d = pc_inc;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dr_q    <= '0;
            t_q     <= '0;
            sp_q    <= '0;
            astb_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ad_q    <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dr_q    <= dr_d;
            t_q     <= t_d;
            sp_q    <= sp_d;
            astb_q  <= astb_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ad_q    <= ad_d;
            tag_q   <= tag_d;
        end
    end

    // Stack contents need no reset: the pointer alone decides what is live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            rstack_q[push_idx] <= pc_inc;
        end
    end

    assign o_astb = astb_q;
    assign o_rd   = rd_q;
    assign o_wr   = wr_q;
    assign o_ad   = ad_q;
    assign o_tag  = tag_q;

`ifdef MICRO_BESM_TRACE_EN
    logic trace_rd_q;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_rd_q <= 1'b0;
        end else begin
            trace_rd_q <= rd_q;
            if (state_q == ST_RUN) begin
                $display("[%0t] pc=%03h uw=%028h", $time, pc_q, uword);
                if (a_d != a_q)   $display("    A=%016h", a_d);
                if (b_d != b_q)   $display("    B=%016h", b_d);
                if (dr_d != dr_q) $display("    D=%016h", dr_d);
                if (t_d != t_q)   $display("    T=%02h", t_d);
            end
            if (astb_q)     $display("ASTB %05h", ad_q[19:0]);
            if (wr_q)       $display("WR %016h %02h", ad_q, tag_q);
            if (trace_rd_q) $display("RD %016h %02h", i_data, i_tag);
        end
    end
`else
    // Default build carries no tracer; cycle behaviour is the same either way.
`endif

endmodule

// File: tb/tb_micro_besm_cpu.sv
// Bench for micro_besm_cpu: directed microprograms plus random ones, checked each cycle
// against an instruction-level interpreter and a tagged-RAM model kept in the bench.
module tb_micro_besm_cpu;
    localparam int RSTACK_D = 4;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic [63:0] i_data = '0;
    logic [7:0]  i_tag  = '0;
    logic [63:0] o_ad;
    logic [7:0]  o_tag;
    logic        o_astb;
    logic        o_rd;
    logic        o_wr;

    micro_besm_cpu #(
        .UADDR_W (12),
        .UWORD_W (112),
        .RSTACK_D(RSTACK_D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .i_data(i_data),
        .i_tag (i_tag),
        .o_ad  (o_ad),
        .o_tag (o_tag),
        .o_astb(o_astb),
        .o_rd  (o_rd),
        .o_wr  (o_wr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pc3_seen = 0;
    int bus_busy = 0;

    logic [111:0] prog  [0:4095];
    logic [63:0]  ram_d [0:1023];
    logic [7:0]   ram_t [0:1023];
    logic [19:0]  ram_addr = '0;

    // Reference machine state
    logic [11:0] m_pc;
    logic [63:0] m_a, m_b, m_d;
    logic [7:0]  m_t;
    logic [11:0] m_stk [$];
    bit          m_halt;
    logic        e_astb, e_rd, e_wr;
    logic [63:0] e_ad;
    logic [7:0]  e_tag;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [111:0] mw(input logic [11:0] nxt, input logic [3:0] seq,
                                        input logic [3:0] bus, input logic [3:0] alu,
                                        input logic [63:0] lit);
        return {nxt, seq, bus, alu, 24'h0, lit};
    endfunction

    task automatic model_reset();
        m_pc = '0; m_a = '0; m_b = '0; m_d = '0; m_t = '0;
        m_stk.delete();
        m_halt = 1'b0;
        e_astb = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_ad = '0; e_tag = '0;
    endtask

    task automatic model_step();
        logic [111:0] w;
        logic [11:0]  nxt, inc, npc;
        logic [3:0]   seq, bus, alu;
        logic [63:0]  lit, a0;
        w   = prog[m_pc];
        nxt = w[111:100]; seq = w[99:96]; bus = w[95:92]; alu = w[91:88]; lit = w[63:0];
        e_astb = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_ad = '0; e_tag = '0;
        if (m_halt) return;
        if (seq == 4'd6) begin
            m_halt = 1'b1;
            return;
        end
        a0 = m_a;
        case (bus)
            4'd1: begin e_astb = 1'b1; e_ad = a0 & 64'hF_FFFF; end
            4'd2: e_rd = 1'b1;
            4'd3: begin e_wr = 1'b1; e_ad = m_d; e_tag = m_t; end
            default: ;
        endcase
        inc = m_pc + 12'd1;
        npc = inc;
        case (seq)
            4'd1: npc = nxt;
            4'd2: if (a0 == 0) npc = nxt;
            4'd3: if (a0 != 0) npc = nxt;
            4'd4: begin
                if (m_stk.size() == RSTACK_D) m_stk[m_stk.size() - 1] = inc;
                else m_stk.push_back(inc);
                npc = nxt;
            end
            4'd5: begin
                if (m_stk.size() == 0) npc = 12'd0;
                else npc = m_stk.pop_back();
            end
            default: ;
        endcase
        m_pc = npc;
        case (alu)
            4'd1:  m_a = lit;
            4'd2:  m_a = a0 + m_b;
            4'd3:  m_a = a0 - m_b;
            4'd4:  m_a = a0 & m_b;
            4'd5:  m_a = a0 | m_b;
            4'd6:  m_a = a0 ^ m_b;
            4'd7:  begin m_a = i_data; m_t = i_tag; end
            4'd8:  m_b = a0;
            4'd9:  m_d = a0;
            4'd10: m_a = a0 + 64'd1;
            4'd11: m_a = a0 * 64'd2;
            4'd12: m_a = a0 / 64'd2;
            4'd13: m_t = lit[7:0];
            default: ;
        endcase
    endtask

    task automatic cycle();
        logic        c_astb, c_rd, c_wr;
        logic [63:0] c_ad;
        logic [7:0]  c_tag;
        model_step();
        c_astb = o_astb; c_rd = o_rd; c_wr = o_wr; c_ad = o_ad; c_tag = o_tag;
        @(posedge clk);
        #1;
        if (c_astb) begin
            ram_addr = c_ad[19:0];
        end else if (c_wr) begin
            ram_d[ram_addr[9:0]] = c_ad;
            ram_t[ram_addr[9:0]] = c_tag;
            ram_addr = ram_addr + 20'd1;
        end else if (c_rd) begin
            i_data = ram_d[ram_addr[9:0]];
            i_tag  = ram_t[ram_addr[9:0]];
            ram_addr = ram_addr + 20'd1;
        end
        chk("bus", 128'({o_astb, o_rd, o_wr, o_tag, o_ad}), 128'({e_astb, e_rd, e_wr, e_tag, e_ad}));
        chk("pc", 128'(dut.pc_q), 128'(m_pc));
        if (dut.pc_q == 12'h003) pc3_seen++;
        if (o_astb || o_rd || o_wr) bus_busy++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog[i] = '0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 4096; i++) dut.memory[i] = prog[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_outputs", 128'({o_astb, o_rd, o_wr, o_tag, o_ad}), 128'(0));
        repeat (2) @(negedge clk);
        chk("rst_pc", 128'(dut.pc_q), 128'(0));
        model_reset();
        reset = 1'b1;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_A"}, 128'(dut.a_q), 128'(m_a));
        chk({tag, "_B"}, 128'(dut.b_q), 128'(m_b));
        chk({tag, "_D"}, 128'(dut.dr_q), 128'(m_d));
        chk({tag, "_T"}, 128'(dut.t_q), 128'(m_t));
    endtask

    initial begin
        logic [3:0] seq;
        int         r;
        for (int i = 0; i < 1024; i++) begin
            ram_d[i] = {$urandom, $urandom};
            ram_t[i] = 8'($urandom);
        end

        // Store: strobe 0x100 then write 0xDEAD with tag 5
        clear_prog();
        prog[0] = mw(12'h0, 4'd0, 4'd0, 4'd1, 64'h100);
        prog[1] = mw(12'h0, 4'd0, 4'd1, 4'd0, 64'h0);
        prog[2] = mw(12'h0, 4'd0, 4'd0, 4'd1, 64'hDEAD);
        prog[3] = mw(12'h0, 4'd0, 4'd0, 4'd9, 64'h0);
        prog[4] = mw(12'h0, 4'd0, 4'd0, 4'd13, 64'h5);
        prog[5] = mw(12'h0, 4'd0, 4'd3, 4'd0, 64'h0);
        prog[6] = mw(12'h0, 4'd6, 4'd0, 4'd0, 64'h0);
        ram_d[12'h100] = '0;
        ram_t[12'h100] = '0;
        load_prog();
        do_reset();
        run(10);
        chk("store_data", 128'(ram_d[12'h100]), 128'(64'hDEAD));
        chk("store_tag", 128'(ram_t[12'h100]), 128'(8'h05));

        // Batch load of two words, summed
        clear_prog();
        ram_d[12'h200] = 64'd7; ram_t[12'h200] = 8'h11;
        ram_d[12'h201] = 64'd9; ram_t[12'h201] = 8'h22;
        prog[0] = mw(12'h0, 4'd0, 4'd0, 4'd1, 64'h200);
        prog[1] = mw(12'h0, 4'd0, 4'd1, 4'd0, 64'h0);
        prog[2] = mw(12'h0, 4'd0, 4'd2, 4'd0, 64'h0);
        prog[3] = mw(12'h0, 4'd0, 4'd2, 4'd0, 64'h0);
        prog[4] = mw(12'h0, 4'd0, 4'd0, 4'd7, 64'h0);
        prog[5] = mw(12'h0, 4'd0, 4'd0, 4'd8, 64'h0);
        prog[6] = mw(12'h0, 4'd0, 4'd0, 4'd7, 64'h0);
        prog[7] = mw(12'h0, 4'd0, 4'd0, 4'd2, 64'h0);
        prog[8] = mw(12'h0, 4'd6, 4'd0, 4'd0, 64'h0);
        load_prog();
        do_reset();
        run(12);
        chk("batch_A", 128'(dut.a_q), 128'(64'd16));
        chk("batch_B", 128'(dut.b_q), 128'(64'd7));
        chk("batch_T", 128'(dut.t_q), 128'(8'h22));

        // Countdown loop: three passes through word 3
        clear_prog();
        prog[0] = mw(12'h0, 4'd0, 4'd0, 4'd1, 64'd1);
        prog[1] = mw(12'h0, 4'd0, 4'd0, 4'd8, 64'h0);
        prog[2] = mw(12'h0, 4'd0, 4'd0, 4'd1, 64'd3);
        prog[3] = mw(12'h0, 4'd0, 4'd0, 4'd3, 64'h0);
        prog[4] = mw(12'h3, 4'd3, 4'd0, 4'd0, 64'h0);
        prog[5] = mw(12'h0, 4'd6, 4'd0, 4'd0, 64'h0);
        load_prog();
        do_reset();
        pc3_seen = 0;
        run(16);
        chk("loop_iters", 128'(pc3_seen), 128'(3));
        chk("loop_A", 128'(dut.a_q), 128'(0));
        chk("loop_pc", 128'(dut.pc_q), 128'(12'h5));

        // Call to 0x40 and return to caller+1
        clear_prog();
        prog[0]     = mw(12'h040, 4'd4, 4'd0, 4'd0, 64'h0);
        prog[1]     = mw(12'h0, 4'd0, 4'd0, 4'd1, 64'h77);
        prog[2]     = mw(12'h0, 4'd6, 4'd0, 4'd0, 64'h0);
        prog[12'h40] = mw(12'h0, 4'd5, 4'd0, 4'd0, 64'h0);
        load_prog();
        do_reset();
        run(6);
        chk("call_pc", 128'(dut.pc_q), 128'(12'h2));
        chk("call_A", 128'(dut.a_q), 128'(64'h77));

        // Return on an empty stack lands on 0
        clear_prog();
        prog[0] = mw(12'h3, 4'd1, 4'd0, 4'd10, 64'h0);
        prog[3] = mw(12'h0, 4'd5, 4'd0, 4'd0, 64'h0);
        load_prog();
        do_reset();
        run(4);
        chk("empty_ret_pc", 128'(dut.pc_q), 128'(0));
        chk("empty_ret_A", 128'(dut.a_q), 128'(64'd2));

        // Continuous writes, then reset mid-transfer
        clear_prog();
        prog[0] = mw(12'h0, 4'd1, 4'd3, 4'd0, 64'h0);
        load_prog();
        do_reset();
        run(3);
        do_reset();

        // Halt at pc 5 with live ALU/BUS fields that must be suppressed
        clear_prog();
        for (int i = 0; i < 5; i++) prog[i] = mw(12'h0, 4'd0, 4'd0, 4'd10, 64'h0);
        prog[5] = mw(12'h0, 4'd6, 4'd3, 4'd1, 64'hFFFF);
        load_prog();
        do_reset();
        run(6);
        bus_busy = 0;
        run(100);
        chk("halt_bus", 128'(bus_busy), 128'(0));
        chk("halt_pc", 128'(dut.pc_q), 128'(12'h5));
        chk("halt_A", 128'(dut.a_q), 128'(64'd5));
        do_reset();
        run(3);

        // Random microprograms against the reference interpreter
        for (int p = 0; p < 16; p++) begin
            clear_prog();
            for (int i = 0; i < 64; i++) begin
                r = $urandom_range(0, 31);
                if (r < 16) seq = 4'd0;
                else seq = 4'($urandom_range(1, 15));
                if (seq == 4'd6 && $urandom_range(0, 7) != 0) seq = 4'd1;
                prog[i] = {12'($urandom_range(0, 63)), seq, 4'($urandom_range(0, 7)),
                           4'($urandom_range(0, 15)), 24'($urandom), $urandom, $urandom};
            end
            load_prog();
            do_reset();
            run(150);
            check_regs("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
